// File: rtl/wb_arbiter.sv
// -----------------------------------------------------------------------------
// wb_arbiter
//
// Write-back arbiter for the pipelined RV32 core. Merges results from the
// in-order execute pipe and from the long-latency unit (load miss, mul/div)
// onto the register file's single write port.
//
// The pipe has absolute priority. It is never back-pressured. Long-latency
// results are buffered in a small FIFO and written in cycles the pipe leaves
// idle. If a non-empty FIFO waits STARVE_MAX cycles without a pop,
// stall_pipe asks upstream to open a slot.
//
// The registered write port (rf_*) doubles as the WB forwarding bus.
// lu_pend_mask tells the hazard unit which registers still have a buffered
// long-latency write outstanding, so it can resolve WAW ordering.
//
// Parameters
//   FIFO_DEPTH  long-latency buffer entries (power of two, >= 2)
//   STARVE_MAX  cycles a non-empty FIFO may wait before stall_pipe (>= 1)
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   pipe_valid/rd/data    execute pipe result (rd == 0 means no write)
//   lu_valid/rd/data      long-latency result (rd == 0 is accepted, discarded)
//   lu_ready              FIFO has room; depends on registered count only
//   stall_pipe            upstream should hold pipe_valid low this cycle
//   lu_pend_mask          bit r set while a buffered entry targets xr
//   rf_we/rd_addr/rd_data registered register-file write / forwarding bus
// -----------------------------------------------------------------------------
module wb_arbiter #(
  parameter int FIFO_DEPTH = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst_n,

  input  logic        pipe_valid,
  input  logic [4:0]  pipe_rd,
  input  logic [31:0] pipe_data,

  input  logic        lu_valid,
  output logic        lu_ready,
  input  logic [4:0]  lu_rd,
  input  logic [31:0] lu_data,

  output logic        stall_pipe,
  output logic [31:0] lu_pend_mask,

  output logic        rf_we,
  output logic [4:0]  rf_rd_addr,
  output logic [31:0] rf_rd_data
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int STV_W = $clog2(STARVE_MAX + 1);

  localparam logic [CNT_W-1:0] DEPTH_C      = CNT_W'(FIFO_DEPTH);
  localparam logic [STV_W-1:0] STARVE_MAX_C = STV_W'(STARVE_MAX);

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_entry_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  wb_entry_t              mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]       count_q,  count_d;
  logic [STV_W-1:0]       starve_q, starve_d;

  logic                   rf_we_q,      rf_we_d;
  logic [4:0]             rf_rd_addr_q, rf_rd_addr_d;
  logic [31:0]            rf_rd_data_q, rf_rd_data_d;

  // ---------------------------------------------------------------------------
  // Slot arbitration
  // ---------------------------------------------------------------------------
  logic                   pipe_claim;
  logic                   push;
  logic                   pop;
  wb_entry_t              head;
  logic [FIFO_DEPTH-1:0]  entry_live;

  assign pipe_claim = pipe_valid && (pipe_rd != 5'd0);

  // lu_ready comes from registered count only, so a full FIFO cannot accept
  // in the same cycle it pops; the freed slot shows up one cycle later.
  assign lu_ready   = (count_q < DEPTH_C);

  // An x0 destination is acknowledged but never stored.
  assign push       = lu_valid && lu_ready && (lu_rd != 5'd0);

  // The head leaves whenever the pipe does not take the slot, stall or not.
  assign pop        = (count_q != '0) && !pipe_claim;

  assign head       = mem_q[rd_ptr_q];

  assign stall_pipe = (starve_q == STARVE_MAX_C) && (count_q != '0);

  // ---------------------------------------------------------------------------
  // FIFO bookkeeping and starvation counter
  // ---------------------------------------------------------------------------
  // NOTE: every variable assigned in an always_comb gets a default at the top
  // of the block; a path that leaves one unassigned infers a latch.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    starve_d = starve_q;

    // Pointers are PTR_W bits wide, so +1 wraps modulo FIFO_DEPTH.
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);

    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    // Measures how long the current head has been denied a slot.
    if ((count_q == '0) || pop) begin
      starve_d = '0;
    end else if (starve_q != STARVE_MAX_C) begin
      starve_d = starve_q + STV_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Next write-port contents: pipe, else FIFO head, else idle.
  // Address and data hold when idle so the forwarding bus does not toggle.
  // ---------------------------------------------------------------------------
  always_comb begin
    rf_we_d      = 1'b0;
    rf_rd_addr_d = rf_rd_addr_q;
    rf_rd_data_d = rf_rd_data_q;

    if (pipe_claim) begin
      rf_we_d      = 1'b1;
      rf_rd_addr_d = pipe_rd;
      rf_rd_data_d = pipe_data;
    end else if (pop) begin
      rf_we_d      = 1'b1;
      rf_rd_addr_d = head.rd;
      rf_rd_data_d = head.data;
    end
  end

  // ---------------------------------------------------------------------------
  // Pending-destination mask over live FIFO entries. An entry is live when its
  // distance from the read pointer is below the count. Entries already moved
  // into the rf_* register are no longer in the FIFO, so they drop out here.
  // ---------------------------------------------------------------------------
  always_comb begin
    entry_live   = '0;
    lu_pend_mask = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      entry_live[i] = ({1'b0, PTR_W'(i) - rd_ptr_q}) < count_q;
      if (entry_live[i]) lu_pend_mask[mem_q[i].rd] = 1'b1;
    end
    // x0 is never enqueued; pin the bit so the hazard unit can rely on it.
    lu_pend_mask[0] = 1'b0;
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop regardless of block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      starve_q     <= '0;
      rf_we_q      <= 1'b0;
      rf_rd_addr_q <= 5'd0;
      rf_rd_data_q <= 32'd0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      starve_q     <= starve_d;
      rf_we_q      <= rf_we_d;
      rf_rd_addr_q <= rf_rd_addr_d;
      rf_rd_data_q <= rf_rd_data_d;
    end
  end

  // NOTE: the entry storage has no reset. Validity is carried entirely by the
  // pointers and count, which do reset, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= '{rd: lu_rd, data: lu_data};
  end

  assign rf_we      = rf_we_q;
  assign rf_rd_addr = rf_rd_addr_q;
  assign rf_rd_data = rf_rd_data_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_wb_arbiter
//
// Directed bench for wb_arbiter (FIFO_DEPTH=2, STARVE_MAX=4). The stimulus
// pushes each expected register-file write into a queue when it is issued; a
// monitor pops and compares on every cycle rf_we is high. Side-band outputs
// (lu_ready, stall_pipe, lu_pend_mask, rf_we) are checked inline.
// Inputs change 1 ns after the rising edge; the monitor samples on the
// falling edge.
// -----------------------------------------------------------------------------
module tb_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pipe_valid;
  logic [4:0]  pipe_rd;
  logic [31:0] pipe_data;
  logic        lu_valid;
  logic        lu_ready;
  logic [4:0]  lu_rd;
  logic [31:0] lu_data;
  logic        stall_pipe;
  logic [31:0] lu_pend_mask;
  logic        rf_we;
  logic [4:0]  rf_rd_addr;
  logic [31:0] rf_rd_data;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];

  wb_arbiter #(.FIFO_DEPTH(2), .STARVE_MAX(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pipe_valid   (pipe_valid),
    .pipe_rd      (pipe_rd),
    .pipe_data    (pipe_data),
    .lu_valid     (lu_valid),
    .lu_ready     (lu_ready),
    .lu_rd        (lu_rd),
    .lu_data      (lu_data),
    .stall_pipe   (stall_pipe),
    .lu_pend_mask (lu_pend_mask),
    .rf_we        (rf_we),
    .rf_rd_addr   (rf_rd_addr),
    .rf_rd_data   (rf_rd_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_pipe(input logic v, input logic [4:0] rd, input logic [31:0] d);
    pipe_valid = v;
    pipe_rd    = rd;
    pipe_data  = d;
  endtask

  task automatic drive_lu(input logic v, input logic [4:0] rd, input logic [31:0] d);
    lu_valid = v;
    lu_rd    = rd;
    lu_data  = d;
  endtask

  task automatic idle();
    drive_pipe(1'b0, 5'd0, 32'd0);
    drive_lu(1'b0, 5'd0, 32'd0);
  endtask

  task automatic expect_wr(input logic [4:0] rd, input logic [31:0] d);
    exp_t e;
    e.rd   = rd;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rf_we"},      32'(rf_we),        32'd0);
    check({tag, "_rf_addr"},    32'(rf_rd_addr),   32'd0);
    check({tag, "_rf_data"},    rf_rd_data,        32'd0);
    check({tag, "_lu_ready"},   32'(lu_ready),     32'd1);
    check({tag, "_stall"},      32'(stall_pipe),   32'd0);
    check({tag, "_pend_mask"},  lu_pend_mask,      32'd0);
  endtask

  // Scoreboard monitor: every write the DUT presents must be the next one
  // the stimulus predicted.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && rf_we) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got addr %0d data %h expected no write",
                   rf_rd_addr, rf_rd_data);
        end else begin
          e = exp_q.pop_front();
          check("wb_addr", 32'(rf_rd_addr), 32'(e.rd));
          check("wb_data", rf_rd_data, e.data);
        end
      end
    end
  end

  // Hard time limit so the bench can never hang.
  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish before 200000");
    $fatal(1, "timeout");
  end

  initial begin
    idle();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // --- Pipe write: claim in cycle 1, rf_we in cycle 2, low in cycle 3.
    drive_pipe(1'b1, 5'd5, 32'hDEAD_BEEF);
    expect_wr(5'd5, 32'hDEAD_BEEF);
    step();
    idle();
    check("t1_we_high", 32'(rf_we), 32'd1);
    step();
    check("t1_we_low", 32'(rf_we), 32'd0);

    // --- Single LU result through an idle slot: mask at N+1, write at N+2.
    drive_lu(1'b1, 5'd7, 32'h0000_1234);
    check("t2_lu_ready", 32'(lu_ready), 32'd1);
    expect_wr(5'd7, 32'h0000_1234);
    step();
    idle();
    check("t2_mask_n1", lu_pend_mask, 32'h0000_0080);
    check("t2_we_n1", 32'(rf_we), 32'd0);
    step();
    check("t2_we_n2", 32'(rf_we), 32'd1);
    check("t2_mask_n2", lu_pend_mask, 32'd0);
    step();

    // --- Pipe claims every cycle while the LU fills the FIFO (rd 3 then 4).
    // Cycle A: first accept.
    drive_pipe(1'b1, 5'd1, 32'h0000_00A0);
    drive_lu(1'b1, 5'd3, 32'h0000_0033);
    check("t3_ready_a0", 32'(lu_ready), 32'd1);
    expect_wr(5'd1, 32'h0000_00A0);
    step();
    // A+1: second accept.
    drive_pipe(1'b1, 5'd1, 32'h0000_00A1);
    drive_lu(1'b1, 5'd4, 32'h0000_0044);
    check("t3_ready_a1", 32'(lu_ready), 32'd1);
    expect_wr(5'd1, 32'h0000_00A1);
    step();
    // A+2: full.
    drive_lu(1'b0, 5'd0, 32'd0);
    drive_pipe(1'b1, 5'd1, 32'h0000_00A2);
    check("t3_full_ready", 32'(lu_ready), 32'd0);
    check("t3_full_mask", lu_pend_mask, 32'h0000_0018);
    check("t3_stall_a2", 32'(stall_pipe), 32'd0);
    expect_wr(5'd1, 32'h0000_00A2);
    step();
    // A+3, A+4: still starving, not yet stalled.
    for (int i = 3; i <= 4; i++) begin
      drive_pipe(1'b1, 5'd1, 32'h0000_00A0 + 32'(i));
      check($sformatf("t3_stall_a%0d", i), 32'(stall_pipe), 32'd0);
      expect_wr(5'd1, 32'h0000_00A0 + 32'(i));
      step();
    end
    // A+5: stall asserted; upstream complies, head (rd 3) pops.
    check("t3_stall_a5", 32'(stall_pipe), 32'd1);
    idle();
    expect_wr(5'd3, 32'h0000_0033);
    step();
    // A+6: stall released, room again; rd 4 pops in this idle slot.
    check("t3_stall_a6", 32'(stall_pipe), 32'd0);
    check("t3_ready_a6", 32'(lu_ready), 32'd1);
    check("t3_mask_a6", lu_pend_mask, 32'h0000_0010);
    expect_wr(5'd4, 32'h0000_0044);
    step();
    step();

    // --- x0 destinations on both sources in the same cycle: no write, no entry.
    drive_pipe(1'b1, 5'd0, 32'h0000_0BAD);
    drive_lu(1'b1, 5'd0, 32'h0000_0BAD);
    check("t4_ready", 32'(lu_ready), 32'd1);
    step();
    idle();
    check("t4_we_n1", 32'(rf_we), 32'd0);
    check("t4_mask_n1", lu_pend_mask, 32'd0);
    check("t4_ready_n1", 32'(lu_ready), 32'd1);
    step();
    check("t4_we_n2", 32'(rf_we), 32'd0);
    check("t4_stall_n2", 32'(stall_pipe), 32'd0);

    // --- Full FIFO plus pipe write, then asynchronous reset mid-cycle.
    drive_pipe(1'b1, 5'd2, 32'h0000_00B0);
    drive_lu(1'b1, 5'd11, 32'h0000_0011);
    expect_wr(5'd2, 32'h0000_00B0);
    step();
    drive_pipe(1'b1, 5'd2, 32'h0000_00B1);
    drive_lu(1'b1, 5'd12, 32'h0000_0012);
    expect_wr(5'd2, 32'h0000_00B1);
    step();
    drive_pipe(1'b1, 5'd2, 32'h0000_00B2);
    drive_lu(1'b0, 5'd0, 32'd0);
    check("t5_full_ready", 32'(lu_ready), 32'd0);
    check("t5_full_mask", lu_pend_mask, 32'h0000_1800);
    check("t5_we_before_rst", 32'(rf_we), 32'd1);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check_reset_outputs("midrst");
    idle();
    step();
    check("midrst_held_we", 32'(rf_we), 32'd0);
    rst_n = 1'b1;
    // First post-reset LU result writes normally.
    drive_lu(1'b1, 5'd6, 32'h0000_0066);
    check("t5_post_ready", 32'(lu_ready), 32'd1);
    expect_wr(5'd6, 32'h0000_0066);
    step();
    idle();
    check("t5_post_mask", lu_pend_mask, 32'h0000_0040);
    step();
    check("t5_post_we", 32'(rf_we), 32'd1);
    step();

    // --- Push and pop in the same cycle at count=1: order rd 9 then rd 10.
    drive_pipe(1'b1, 5'd1, 32'h0000_00C0);
    drive_lu(1'b1, 5'd9, 32'h0000_0099);
    expect_wr(5'd1, 32'h0000_00C0);
    expect_wr(5'd9, 32'h0000_0099);
    step();
    drive_pipe(1'b0, 5'd0, 32'd0);
    drive_lu(1'b1, 5'd10, 32'h0000_1010);
    check("t6_mask_c1", lu_pend_mask, 32'h0000_0200);
    expect_wr(5'd10, 32'h0000_1010);
    step();
    idle();
    check("t6_mask_c2", lu_pend_mask, 32'h0000_0400);
    check("t6_ready_c2", 32'(lu_ready), 32'd1);
    step();
    check("t6_mask_c3", lu_pend_mask, 32'd0);

    // Drain: every predicted write must have appeared within a bounded wait.
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) step();
    check("drain_pending", 32'(exp_q.size()), 32'd0);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
